mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Memory-side companion to the single-cycle core; the core itself contains no memory controller.
- Accepts the core's instruction fetch, load and store requests and serialises them onto one external word-wide bus.
- The bus uses a request/acknowledge handshake with variable latency.
- Returns fetched and loaded words with a one-cycle ready pulse per request.

Parameters:
- W, 32, data/address word width (`WORD_WIDTH).
- TIMEOUT, 255, bus-wait cycles before abort; used only with the optional feature.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request, held until if_ready.
- if_addr  in  W  fetch address.
- if_data  out  W  fetched word; valid while if_ready is high.
- if_ready  out  1  one-cycle fetch completion pulse.
- ld_req  in  1  load request, held until ld_ready.
- ld_addr  in  W  load address.
- ld_data  out  W  loaded word; valid while ld_ready is high.
- ld_ready  out  1  one-cycle load completion pulse.
- st_req  in  1  store request, held until st_ready.
- st_addr  in  W  store address.
- st_data  in  W  store data.
- st_strb  in  W/8  byte strobes; bit i enables byte lane i.
- st_ready  out  1  one-cycle store completion pulse.
- bus_req  out  1  bus transaction active.
- bus_we  out  1  1 = write, 0 = read.
- bus_addr  out  W  word-aligned address.
- bus_wdata  out  W  write data.
- bus_strb  out  W/8  write strobes; all ones on reads.
- bus_ack  in  1  bus completion, one cycle.
- bus_rdata  in  W  read data, valid with bus_ack.
- bus_err  out  1  sticky timeout flag; exists only with the optional feature.

Behaviour:
- Reset: state IDLE. All ready outputs, bus_req, bus_we and bus_err are 0. All data, address and strobe outputs are 0.
- States:
  - IDLE: samples requests each cycle.
  - BUS: bus_req is high; waiting for bus_ack.
  - RESP: exactly one ready pulse; always returns to IDLE next cycle.
- Arbitration in IDLE is fixed priority: st_req > ld_req > if_req. Losers keep waiting with their req held.
- IDLE to BUS on a grant. At that edge, register bus_addr = {addr[W-1:2], 2'b00}; address bits [1:0] are ignored.
  - Store grant: also register bus_we = 1, bus_wdata = st_data, bus_strb = st_strb.
  - Read grant: also register bus_we = 0 and bus_strb all ones.
  - Also record which requester was granted.
- Zero-strobe store: a granted store with st_strb == 0 goes IDLE to RESP directly. No bus cycle is issued.
- All bus outputs stay constant while bus_req is high.
- BUS to RESP on bus_ack. For a read, bus_rdata is captured into the granted requester's data register at that edge.
- In RESP, only the granted requester's ready is high.
- if_data and ld_data hold their last captured value until the next capture of the same type.
- Latency: a request is seen in IDLE at cycle 0 and bus_req rises at cycle 1. With ack in cycle k, ready is high in cycle k+1. Minimum is 3 cycles (ack in cycle 1).
- A requester must drop req by the edge ending its ready cycle. A req still high one cycle after ready is treated as a new request.
- bus_ack in IDLE or RESP is ignored.
- Simultaneous requests: if all three are raised together, the completion order is store, load, fetch. No requester is granted twice while others wait.
- Reset mid-transaction: the state is forced to IDLE and bus_req drops the cycle after rst. A later stale bus_ack is ignored and no ready pulse is produced.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- When defined:
  - An 8-bit or wider counter clears on entering BUS and increments each BUS cycle without ack.
  - When the counter reaches TIMEOUT, go to RESP and set bus_err = 1.
  - bus_err is sticky until rst.
  - Read data is forced to 0xFFFFFFFF.
- When undefined: no counter, no bus_err port, and BUS waits indefinitely.

Test Plan:
- Fetch: if_req=1, if_addr=0x00400004, bus_ack in cycle 1 with rdata=0x24080005 -> bus_addr=0x00400004, bus_we=0; if_ready pulse in cycle 2 with if_data=0x24080005.
- Store: st_req with st_addr=0x10010003, st_data=0xDEADBEEF, strb=4'b0011, ack after 4 wait cycles -> bus_addr=0x10010000, bus_we=1, bus_strb=0011; bus outputs stable for all 5 bus cycles; st_ready once.
- Simultaneous if/ld/st requests, ack in cycle 1 each time -> ready pulses in order st, ld, if, at cycles 2, 5, 8.
- Zero-strobe store -> no bus_req; st_ready in cycle 1.
- rst asserted while in BUS, then ack arrives 2 cycles later -> bus_req=0 after rst; no ready pulse; next fetch completes normally.
- MEM_ARB_TIMEOUT_EN with TIMEOUT=8 and no ack on a load -> ld_ready after 8 wait cycles with ld_data=0xFFFFFFFF; bus_err=1 and it persists.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises the core's instruction fetch, load and store
// requests onto a single word-wide request/acknowledge memory bus.
// Arbitration is fixed priority: store > load > fetch.
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   if_req/if_addr/if_data/if_ready fetch requester (ready is a 1-cycle pulse)
//   ld_req/ld_addr/ld_data/ld_ready load requester (ready is a 1-cycle pulse)
//   st_req/st_addr/st_data/st_strb/st_ready store requester
//   bus_req/bus_we/bus_addr/bus_wdata/bus_strb  bus command, held while bus_req
//   bus_ack/bus_rdata               bus completion and read data
//   bus_err                         sticky timeout flag (MEM_ARB_TIMEOUT_EN only)
//
// Optional build macro: MEM_ARB_TIMEOUT_EN enables a bus-wait counter that
// aborts a transaction after TIMEOUT unacknowledged cycles.
module mem_arbiter #(
  parameter int unsigned W       = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           if_req,
  input  logic [W-1:0]   if_addr,
  output logic [W-1:0]   if_data,
  output logic           if_ready,
  input  logic           ld_req,
  input  logic [W-1:0]   ld_addr,
  output logic [W-1:0]   ld_data,
  output logic           ld_ready,
  input  logic           st_req,
  input  logic [W-1:0]   st_addr,
  input  logic [W-1:0]   st_data,
  input  logic [W/8-1:0] st_strb,
  output logic           st_ready,
  output logic           bus_req,
  output logic           bus_we,
  output logic [W-1:0]   bus_addr,
  output logic [W-1:0]   bus_wdata,
  output logic [W/8-1:0] bus_strb,
  input  logic           bus_ack,
  input  logic [W-1:0]   bus_rdata
`ifdef MEM_ARB_TIMEOUT_EN
  ,
  output logic           bus_err
`endif
);

  localparam int unsigned SW = W / 8;
  // Word alignment: clearing bits [1:0] rather than slicing keeps every
  // address bit formally consumed.
  localparam logic [W-1:0] ADDR_MASK = {{(W-2){1'b1}}, 2'b00};

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_e;
  typedef enum logic [1:0] {G_IF, G_LD, G_ST}      grant_e;

  state_e        state_q, state_d;
  grant_e        grant_q, grant_d;
  logic          bus_req_q, bus_req_d;
  logic          bus_we_q, bus_we_d;
  logic [W-1:0]  bus_addr_q, bus_addr_d;
  logic [W-1:0]  bus_wdata_q, bus_wdata_d;
  logic [SW-1:0] bus_strb_q, bus_strb_d;
  logic [W-1:0]  if_data_q, if_data_d;
  logic [W-1:0]  ld_data_q, ld_data_d;
  logic          if_ready_q, if_ready_d;
  logic          ld_ready_q, ld_ready_d;
  logic          st_ready_q, st_ready_d;
  logic          done;
  logic [W-1:0]  rdata_v;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  // Abort when this cycle would bring the count of unacknowledged cycles to TIMEOUT.
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
`endif

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_strb_d  = bus_strb_q;
    if_data_d   = if_data_q;
    ld_data_d   = ld_data_q;
    if_ready_d  = 1'b0;
    ld_ready_d  = 1'b0;
    st_ready_d  = 1'b0;
    done        = 1'b0;
    rdata_v     = bus_rdata;
`ifdef MEM_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
    err_d       = err_q;
`endif
    unique case (state_q)
      S_IDLE: begin
`ifdef MEM_ARB_TIMEOUT_EN
        cnt_d = '0;
`endif
        if (st_req) begin
          grant_d = G_ST;
          if (st_strb == '0) begin
            // Nothing to write: complete without touching the bus.
            state_d    = S_RESP;
            st_ready_d = 1'b1;
          end else begin
            state_d     = S_BUS;
            bus_req_d   = 1'b1;
            bus_we_d    = 1'b1;
            bus_addr_d  = st_addr & ADDR_MASK;
            bus_wdata_d = st_data;
            bus_strb_d  = st_strb;
          end
        end else if (ld_req) begin
          grant_d    = G_LD;
          state_d    = S_BUS;
          bus_req_d  = 1'b1;
          bus_we_d   = 1'b0;
          bus_addr_d = ld_addr & ADDR_MASK;
          bus_strb_d = '1;
        end else if (if_req) begin
          grant_d    = G_IF;
          state_d    = S_BUS;
          bus_req_d  = 1'b1;
          bus_we_d   = 1'b0;
          bus_addr_d = if_addr & ADDR_MASK;
          bus_strb_d = '1;
        end
      end
      S_BUS: begin
        done = bus_ack;
`ifdef MEM_ARB_TIMEOUT_EN
        if (!bus_ack) begin
          if (cnt_q == TO_LAST) begin
            done    = 1'b1;
            rdata_v = '1;
            err_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
`endif
        if (done) begin
          state_d   = S_RESP;
          bus_req_d = 1'b0;
          unique case (grant_q)
            G_IF: begin
              if_data_d  = rdata_v;
              if_ready_d = 1'b1;
            end
            G_LD: begin
              ld_data_d  = rdata_v;
              ld_ready_d = 1'b1;
            end
            G_ST:    st_ready_d = 1'b1;
            default: ;
          endcase
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      grant_q     <= G_IF;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_strb_q  <= '0;
      if_data_q   <= '0;
      ld_data_q   <= '0;
      if_ready_q  <= 1'b0;
      ld_ready_q  <= 1'b0;
      st_ready_q  <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_strb_q  <= bus_strb_d;
      if_data_q   <= if_data_d;
      ld_data_q   <= ld_data_d;
      if_ready_q  <= if_ready_d;
      ld_ready_q  <= ld_ready_d;
      st_ready_q  <= st_ready_d;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
      err_q       <= err_d;
`endif
    end
  end

  assign if_data   = if_data_q;
  assign if_ready  = if_ready_q;
  assign ld_data   = ld_data_q;
  assign ld_ready  = ld_ready_q;
  assign st_ready  = st_ready_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_strb  = bus_strb_q;
`ifdef MEM_ARB_TIMEOUT_EN
  assign bus_err   = err_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed test-plan scenarios plus randomized
// request mixes, checked against a schedule computed from the arbitration
// and latency rules. Build with MEM_ARB_TIMEOUT_EN to also exercise timeout.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, ld_req, st_req;
  logic [31:0] if_addr, ld_addr, st_addr, st_data;
  logic [3:0]  st_strb;
  logic [31:0] if_data, ld_data;
  logic        if_ready, ld_ready, st_ready;
  logic        bus_req, bus_we, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_strb;
`ifdef MEM_ARB_TIMEOUT_EN
  logic        bus_err;
`endif

  int checks = 0;
  int errors = 0;

  // Scenario description (index 0 = fetch, 1 = load, 2 = store)
  logic [2:0]  s_mask;
  logic [31:0] s_addr [3];
  logic [31:0] s_rdata[3];
  int          s_wait [3];
  logic [31:0] s_wdata;
  logic [3:0]  s_strb;

  // Expected schedule and model state
  int          busfrom[3], busto[3], rdy[3];
  logic [31:0] exp_if, exp_ld;

`ifdef MEM_ARB_TIMEOUT_EN
  mem_arbiter #(.W(32), .TIMEOUT(8)) dut (
`else
  mem_arbiter #(.W(32)) dut (
`endif
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_data(if_data), .if_ready(if_ready),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
    .st_req(st_req), .st_addr(st_addr), .st_data(st_data), .st_strb(st_strb),
    .st_ready(st_ready),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_strb(bus_strb), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
`ifdef MEM_ARB_TIMEOUT_EN
    , .bus_err(bus_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Called in an idle cycle ("cycle 0"). Raises the chosen requests together,
  // plays the bus slave, and checks every cycle against a schedule derived
  // from priority order and the fixed per-transaction latency.
  task automatic run_scenario();
    int t;
    int last;
    int br;
    t = 0;
    for (int k = 0; k < 3; k++) begin
      int r;
      r = 2 - k;
      busfrom[r] = -10; busto[r] = -20; rdy[r] = -30;
      if (s_mask[r]) begin
        if (r == 2 && s_strb == 4'h0) begin
          rdy[r] = t + 1;
        end else begin
          busfrom[r] = t + 1;
          busto[r]   = t + 1 + s_wait[r];
          rdy[r]     = busto[r] + 1;
        end
        t = rdy[r] + 1;
      end
    end
    last = t;
    if_addr = s_addr[0]; ld_addr = s_addr[1]; st_addr = s_addr[2];
    st_data = s_wdata;   st_strb = s_strb;
    if_req = s_mask[0];  ld_req = s_mask[1]; st_req = s_mask[2];
    for (int cyc = 1; cyc <= last; cyc++) begin
      tick();
      br = -1;
      for (int r = 0; r < 3; r++)
        if (cyc >= busfrom[r] && cyc <= busto[r]) br = r;
      if (cyc == rdy[0]) exp_if = s_rdata[0];
      if (cyc == rdy[1]) exp_ld = s_rdata[1];
      chk1("bus_req", bus_req, br >= 0);
      if (br >= 0) begin
        chk32("bus_addr", bus_addr, s_addr[br] & 32'hFFFF_FFFC);
        chk1("bus_we", bus_we, br == 2);
        chk32("bus_strb", 32'(bus_strb), (br == 2) ? 32'(s_strb) : 32'hF);
        if (br == 2) chk32("bus_wdata", bus_wdata, s_wdata);
      end
      chk1("if_ready", if_ready, cyc == rdy[0]);
      chk1("ld_ready", ld_ready, cyc == rdy[1]);
      chk1("st_ready", st_ready, cyc == rdy[2]);
      chk32("if_data", if_data, exp_if);
      chk32("ld_data", ld_data, exp_ld);
`ifdef MEM_ARB_TIMEOUT_EN
      chk1("bus_err", bus_err, 1'b0);
`endif
      if (br >= 0) begin
        bus_ack   = (cyc == busto[br]);
        bus_rdata = bus_ack ? s_rdata[br] : $urandom();
      end else begin
        // Stray acks outside a bus transaction must be ignored.
        bus_ack   = ($urandom_range(0, 3) == 0);
        bus_rdata = $urandom();
      end
      if (cyc == rdy[0]) if_req = 1'b0;
      if (cyc == rdy[1]) ld_req = 1'b0;
      if (cyc == rdy[2]) st_req = 1'b0;
    end
    bus_ack = 1'b0;
  endtask

  task automatic set_defaults();
    s_mask = 3'b000;
    for (int i = 0; i < 3; i++) begin
      s_addr[i] = $urandom(); s_rdata[i] = $urandom(); s_wait[i] = 0;
    end
    s_wdata = $urandom();
    s_strb  = 4'hF;
  endtask

  initial begin
    rst = 1'b1;
    if_req = 0; ld_req = 0; st_req = 0;
    if_addr = '0; ld_addr = '0; st_addr = '0; st_data = '0; st_strb = '0;
    bus_ack = 0; bus_rdata = '0;
    exp_if = '0; exp_ld = '0;
    tick();
    tick();
    // Reset state
    chk1("rst_bus_req", bus_req, 1'b0);
    chk1("rst_bus_we", bus_we, 1'b0);
    chk32("rst_bus_addr", bus_addr, 32'h0);
    chk32("rst_bus_wdata", bus_wdata, 32'h0);
    chk32("rst_bus_strb", 32'(bus_strb), 32'h0);
    chk1("rst_if_ready", if_ready, 1'b0);
    chk1("rst_ld_ready", ld_ready, 1'b0);
    chk1("rst_st_ready", st_ready, 1'b0);
    chk32("rst_if_data", if_data, 32'h0);
    chk32("rst_ld_data", ld_data, 32'h0);
`ifdef MEM_ARB_TIMEOUT_EN
    chk1("rst_bus_err", bus_err, 1'b0);
`endif
    rst = 1'b0;

    // Fetch, ack in cycle 1
    set_defaults();
    s_mask = 3'b001; s_addr[0] = 32'h0040_0004; s_rdata[0] = 32'h2408_0005;
    run_scenario();

    // Store with unaligned address, partial strobes, 4 wait cycles
    set_defaults();
    s_mask = 3'b100; s_addr[2] = 32'h1001_0003; s_wdata = 32'hDEAD_BEEF;
    s_strb = 4'b0011; s_wait[2] = 4;
    run_scenario();

    // All three together, ack in cycle 1 each: st@2, ld@5, if@8
    set_defaults();
    s_mask = 3'b111;
    run_scenario();

    // Zero-strobe store: no bus cycle, st_ready in cycle 1
    set_defaults();
    s_mask = 3'b100; s_strb = 4'b0000;
    run_scenario();

    // Reset while in BUS, stale ack afterwards
    if_addr = 32'h0000_1000; if_req = 1'b1;
    tick();
    chk1("rstmid_bus_req_c1", bus_req, 1'b1);
    tick();
    chk1("rstmid_bus_req_c2", bus_req, 1'b1);
    rst = 1'b1; if_req = 1'b0;
    tick();
    exp_if = '0; exp_ld = '0;
    chk1("rstmid_bus_req_c3", bus_req, 1'b0);
    rst = 1'b0;
    tick();
    bus_ack = 1'b1; bus_rdata = 32'hBAD0_BAD0;
    chk1("rstmid_if_ready_c4", if_ready, 1'b0);
    for (int c = 5; c <= 7; c++) begin
      tick();
      bus_ack = 1'b0;
      chk1("rstmid_bus_req", bus_req, 1'b0);
      chk1("rstmid_if_ready", if_ready, 1'b0);
      chk1("rstmid_ld_ready", ld_ready, 1'b0);
      chk1("rstmid_st_ready", st_ready, 1'b0);
      chk32("rstmid_if_data", if_data, 32'h0);
    end

    // Normal fetch after the reset
    set_defaults();
    s_mask = 3'b001; s_wait[0] = 2;
    run_scenario();

    // Randomized request mixes
    for (int n = 0; n < 40; n++) begin
      set_defaults();
      s_mask = 3'($urandom_range(1, 7));
      s_strb = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      for (int i = 0; i < 3; i++) s_wait[i] = int'($urandom_range(0, 6));
      run_scenario();
    end

`ifdef MEM_ARB_TIMEOUT_EN
    // Load with no ack: aborts after 8 unacknowledged bus cycles
    ld_addr = $urandom(); ld_req = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      chk1("to_bus_req", bus_req, 1'b1);
      chk1("to_ld_ready", ld_ready, 1'b0);
      chk1("to_bus_err", bus_err, 1'b0);
    end
    tick();
    chk1("to_ld_ready_pulse", ld_ready, 1'b1);
    chk32("to_ld_data", ld_data, 32'hFFFF_FFFF);
    chk1("to_bus_err_set", bus_err, 1'b1);
    chk1("to_bus_req_low", bus_req, 1'b0);
    ld_req = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk1("to_bus_err_sticky", bus_err, 1'b1);
      chk1("to_ld_ready_low", ld_ready, 1'b0);
      chk32("to_ld_data_hold", ld_data, 32'hFFFF_FFFF);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
